// File: rtl/decimal_key_encoder_pkg.sv
// Shared types and helpers for the decimal key encoder: FSM states, the
// no-key code and the priority encoder used on the synchronised key lines.
package decimal_key_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] NO_KEY = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  // Returns {any, code}; later (higher) indices overwrite lower ones so 9 beats 0
  function automatic logic [BCD_W:0] prio_encode(logic [9:0] n);
    logic [BCD_W:0] r;
    r = {1'b0, NO_KEY};
    for (int i = 0; i < 10; i++) begin
      if (!n[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/decimal_key_encoder_if.sv
// Valid/ready stream carrying debounced BCD key codes to the consumer.
interface decimal_key_encoder_if;
  import decimal_key_pkg::*;

  logic [BCD_W-1:0] out_bcd;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_bcd, output out_valid, input out_ready);
  modport slave  (input out_bcd, input out_valid, output out_ready);
endinterface

// File: rtl/decimal_key_encoder_fifo.sv
// Small circular FIFO holding accepted key codes; a push into a full FIFO
// only lands when a pop frees the head slot in the same cycle.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decimal_key_encoder.sv
// Front-panel decimal key encoder: synchronises ten active-low key lines,
// priority-encodes and debounces them, and queues one BCD code per press.
module decimal_key_encoder
  import decimal_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            in_n,
  decimal_key_encoder_if.master bus,
  output logic                  key_held,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       sync1_q, sync2_q;
  logic [BCD_W:0]   enc;
  logic             any;
  logic [BCD_W-1:0] code;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] cand_q, cand_d;
  logic             push_req;

  logic             pop, fifo_push, fifo_empty, fifo_full;
  logic [BCD_W-1:0] fifo_dout;

  // Idle-high reset value makes a key held through reset look like a new press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 10'h3FF;
      sync2_q <= 10'h3FF;
    end else begin
      sync1_q <= in_n;
      sync2_q <= sync1_q;
    end
  end

  assign enc  = prio_encode(sync2_q);
  assign any  = enc[BCD_W];
  assign code = enc[BCD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= NO_KEY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Code changes while held are ignored until a fully debounced release
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          cand_d  = code;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!any || (code != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          push_req = 1'b1;
          state_d  = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!any) begin
          cnt_d   = '0;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (any) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_held  = (state_q == HELD) || (state_q == DB_RELEASE);
  assign pop       = bus.out_valid && bus.out_ready;
  assign fifo_push = push_req && (!fifo_full || pop);

  key_fifo #(
    .WIDTH (BCD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (cand_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.out_bcd   = fifo_dout;
  assign bus.out_valid = !fifo_empty;

  // A new drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Scoreboard bench for decimal_key_encoder with a short debounce window;
// expected codes are queued at stimulus time and checked by a monitor.
module tb_decimal_key_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_n;
  logic       key_held;
  logic       ovf;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  decimal_key_encoder_if bus();

  decimal_key_encoder #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_n     (in_n),
    .bus      (bus),
    .key_held (key_held),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] value, input int cycles);
    in_n = value;
    repeat (cycles) tick();
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.out_valid) break;
    end
  endtask

  // Monitor: every accepted output beat must match the oldest expected code
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checkOutput("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_bcd", int'(bus.out_bcd), int'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    in_n          = 10'h3FF;
    ovf_clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("reset_valid", int'(bus.out_valid), 0);
    checkOutput("reset_bcd", int'(bus.out_bcd), 0);
    checkOutput("reset_held", int'(key_held), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] T1 clean press digit 3");
    exp_q.push_back(4'd3);
    in_n = 10'h3F7;
    waitValid(n);
    checkOutput("t1_latency", n, 7);
    checkOutput("t1_held_on", int'(key_held), 1);
    repeat (20 - n) tick();
    in_n = 10'h3FF;
    repeat (6) tick();
    checkOutput("t1_held_before_idle", int'(key_held), 1);
    tick();
    checkOutput("t1_held_after_idle", int'(key_held), 0);
    repeat (3) tick();
    checkOutput("t1_drained", exp_q.size(), 0);

    $display("[TB] T2 glitch digit 5");
    in_n = 10'h3DF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_held_glitch", int'(key_held), 0);
    end
    in_n = 10'h3FF;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t2_held_after", int'(key_held), 0);
      checkOutput("t2_no_valid", int'(bus.out_valid), 0);
    end

    $display("[TB] T3 priority 8 over 2, partial release");
    exp_q.push_back(4'd8);
    applyStimulus(10'h2FB, 12);
    checkOutput("t3_held", int'(key_held), 1);
    applyStimulus(10'h3FB, 12);
    checkOutput("t3_still_held", int'(key_held), 1);
    checkOutput("t3_no_second_valid", int'(bus.out_valid), 0);
    applyStimulus(10'h3FF, 12);
    checkOutput("t3_released", int'(key_held), 0);
    checkOutput("t3_drained", exp_q.size(), 0);

    $display("[TB] T4 release bounce digit 6");
    exp_q.push_back(4'd6);
    applyStimulus(10'h3BF, 10);
    for (int b = 0; b < 2; b++) begin
      in_n = 10'h3FF;
      for (int i = 0; i < 2; i++) begin
        tick();
        checkOutput("t4_held_bounce_hi", int'(key_held), 1);
      end
      in_n = 10'h3BF;
      tick();
      checkOutput("t4_held_bounce_lo", int'(key_held), 1);
    end
    in_n = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t4_held_release", int'(key_held), 1);
    end
    repeat (7) tick();
    checkOutput("t4_released", int'(key_held), 0);
    checkOutput("t4_drained", exp_q.size(), 0);

    $display("[TB] T5 overflow with consumer stalled");
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [9:0] v;
      v = 10'h3FF;
      v[k] = 1'b0;
      if (k <= 4) exp_q.push_back(4'(k));
      applyStimulus(v, 10);
      applyStimulus(10'h3FF, 10);
    end
    checkOutput("t5_ovf_set", int'(ovf), 1);
    checkOutput("t5_valid", int'(bus.out_valid), 1);
    checkOutput("t5_head", int'(bus.out_bcd), 1);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    checkOutput("t5_drained", exp_q.size(), 0);
    checkOutput("t5_empty", int'(bus.out_valid), 0);
    checkOutput("t5_empty_bcd", int'(bus.out_bcd), 0);
    checkOutput("t5_ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("t5_ovf_cleared", int'(ovf), 0);

    $display("[TB] T6 reset during debounce digit 9");
    in_n = 10'h1FF;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_reset_valid", int'(bus.out_valid), 0);
    checkOutput("t6_reset_bcd", int'(bus.out_bcd), 0);
    checkOutput("t6_reset_held", int'(key_held), 0);
    checkOutput("t6_reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    exp_q.push_back(4'd9);
    waitValid(n);
    checkOutput("t6_latency", n, 7);
    applyStimulus(10'h1FF, 5);
    applyStimulus(10'h3FF, 12);
    checkOutput("t6_released", int'(key_held), 0);
    checkOutput("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
